// File: rtl/life_pkg.sv
// Shared definitions for the 4x4 Game of Life generation engine.
// Contents: board geometry, the (x, y) -> bit-index helper and the
// controller state encoding.
package life_pkg;

  localparam int GRID_W = 4;
  localparam int GRID_H = 4;
  localparam int CELLS  = GRID_W * GRID_H;

  // IDLE waits for a trigger, COMPUTE walks the 16 cells, COMMIT publishes.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  // Board bit index of cell (x, y): index = y*4 + x.
  function automatic logic [3:0] cell_idx(input logic [1:0] x, input logic [1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// B3/S23 rule for a single cell.
// Ports:
//   nbr_i  [7:0]  the eight neighbour cells (order irrelevant)
//   cell_i        current value of the cell itself
//   next_o        value of the cell in the next generation
module life_cell_rule (
  input  logic [7:0] nbr_i,
  input  logic       cell_i,
  output logic       next_o
);

  logic [3:0] count_s;

  // Live-neighbour population count, range 0..8.
  always_comb begin
    count_s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_s = count_s + {3'd0, nbr_i[i]};
    end
  end

  // Three neighbours give birth, two keep the cell as it is, anything else kills it.
  always_comb begin
    case (count_s)
      4'd3:    next_o = 1'b1;
      4'd2:    next_o = cell_i;
      default: next_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/life_engine_4x4.sv
// Generation engine for a 4x4 Game of Life board.
// The board is held in alive_q. A trigger (step, run-mode frame pacing)
// starts a 16-cycle sweep that evaluates one cell per cycle from the frozen
// board into next_q; a single COMMIT cycle then publishes all 16 cells at
// once, so the display never sees a half-computed generation.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   frame_tick         one-cycle pulse at the start of vertical blanking
//   run                level, enables free-run pacing
//   step               one-cycle pulse, requests one generation
//   load, load_pattern one-cycle pulse replacing the board (aborts a sweep)
//   alive [15:0]       current board, bit = y*4 + x
//   busy               high while a generation is in progress
//   done               one-cycle pulse after a commit
//   generation [15:0]  committed generations since reset or load
module life_engine_4x4
  import life_pkg::*;
#(
  parameter int unsigned FRAMES_PER_GEN = 30,
  parameter bit          WRAP           = 1'b0,
  parameter logic [15:0] INIT_PATTERN   = 16'h0070
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        run,
  input  logic        step,
  input  logic        load,
  input  logic [15:0] load_pattern,
  output logic [15:0] alive,
  output logic        busy,
  output logic        done,
  output logic [15:0] generation
);

  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_GEN - 1);
  localparam logic [3:0] LAST_IDX   = 4'(CELLS - 1);

  state_e      state_q, state_d;
  logic [15:0] alive_q;
  logic [15:0] next_q;
  logic [15:0] gen_q;
  logic [7:0]  frame_cnt_q;
  logic [3:0]  idx_q;
  logic        done_q;

  logic        pace_hit_s;
  logic [1:0]  cx_s, cy_s;
  logic [7:0]  nbr_s;
  logic        rule_next_s;

  // Neighbour at offset (dx, dy); off-board cells are dead unless WRAP folds them mod 4.
  function automatic logic nbr_bit(input logic [15:0] b, input logic [1:0] x,
                                   input logic [1:0] y, input int dx, input int dy);
    int   nx;
    int   ny;
    logic on_board;
    nx       = int'(x) + dx;
    ny       = int'(y) + dy;
    on_board = (nx >= 0) && (nx < GRID_W) && (ny >= 0) && (ny < GRID_H);
    if (WRAP || on_board) begin
      return b[cell_idx(2'(nx), 2'(ny))];
    end else begin
      return 1'b0;
    end
  endfunction

  assign pace_hit_s = run && frame_tick && (frame_cnt_q == FRAME_LAST);
  assign cx_s       = idx_q[1:0];
  assign cy_s       = idx_q[3:2];

  // Gather the eight neighbours of the cell currently being evaluated.
  always_comb begin
    nbr_s[0] = nbr_bit(alive_q, cx_s, cy_s, -1, -1);
    nbr_s[1] = nbr_bit(alive_q, cx_s, cy_s,  0, -1);
    nbr_s[2] = nbr_bit(alive_q, cx_s, cy_s,  1, -1);
    nbr_s[3] = nbr_bit(alive_q, cx_s, cy_s, -1,  0);
    nbr_s[4] = nbr_bit(alive_q, cx_s, cy_s,  1,  0);
    nbr_s[5] = nbr_bit(alive_q, cx_s, cy_s, -1,  1);
    nbr_s[6] = nbr_bit(alive_q, cx_s, cy_s,  0,  1);
    nbr_s[7] = nbr_bit(alive_q, cx_s, cy_s,  1,  1);
  end

  life_cell_rule u_rule (
    .nbr_i  (nbr_s),
    .cell_i (alive_q[idx_q]),
    .next_o (rule_next_s)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; load always wins and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!load && (step || pace_hit_s)) state_d = COMPUTE;
        else                               state_d = IDLE;
      end
      COMPUTE: begin
        if (load)                    state_d = IDLE;
        else if (idx_q == LAST_IDX)  state_d = COMMIT;
        else                         state_d = COMPUTE;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Board, sweep, pacing and generation datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      alive_q     <= INIT_PATTERN;
      next_q      <= 16'h0000;
      gen_q       <= 16'h0000;
      frame_cnt_q <= 8'd0;
      idx_q       <= 4'd0;
      done_q      <= 1'b0;
    end else begin
      // A load during COMMIT discards the generation, so no done pulse.
      done_q <= (state_q == COMMIT) && !load;
      if (load) begin
        alive_q     <= load_pattern;
        gen_q       <= 16'h0000;
        frame_cnt_q <= 8'd0;
        idx_q       <= 4'd0;
      end else begin
        case (state_q)
          IDLE: begin
            idx_q <= 4'd0;
            // A simultaneous step takes priority and the tick is not counted.
            if (!step && run && frame_tick) begin
              frame_cnt_q <= pace_hit_s ? 8'd0 : frame_cnt_q + 8'd1;
            end
          end
          COMPUTE: begin
            next_q[idx_q] <= rule_next_s;
            idx_q         <= idx_q + 4'd1;
          end
          COMMIT: begin
            alive_q <= next_q;
            gen_q   <= gen_q + 16'd1;
          end
          default: idx_q <= 4'd0;
        endcase
      end
    end
  end

  assign alive      = alive_q;
  assign done       = done_q;
  assign generation = gen_q;

endmodule

// File: tb/tb_life_engine_4x4.sv
module tb_life_engine_4x4;

  logic        clk = 1'b0;
  logic        reset, frame_tick, run, step, load;
  logic [15:0] load_pattern;
  logic [15:0] alive0, alive1, gen0, gen1;
  logic        busy0, busy1, done0, done1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  life_engine_4x4 #(.FRAMES_PER_GEN(3), .WRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .step(step),
    .load(load), .load_pattern(load_pattern),
    .alive(alive0), .busy(busy0), .done(done0), .generation(gen0)
  );

  life_engine_4x4 #(.FRAMES_PER_GEN(3), .WRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .step(step),
    .load(load), .load_pattern(load_pattern),
    .alive(alive1), .busy(busy1), .done(done1), .generation(gen1)
  );

  typedef struct {
    logic        do_load;
    logic [15:0] pat;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic [15:0] exp_gen;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_pulse();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic load_pulse(input logic [15:0] p);
    load_pattern = p;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // n counts edges after the trigger edge; done is expected at n=17.
  task automatic observe(input int ncyc, output int busy_cnt, output int done_cnt, output int done_at);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int n = 0; n < ncyc; n++) begin
      if (busy0) busy_cnt++;
      if (done0) begin
        done_cnt++;
        done_at = n;
      end
      tick();
    end
  endtask

  initial begin
    int bc, dc, da;
    int total_done;

    reset = 1'b1; frame_tick = 1'b0; run = 1'b0; step = 1'b0; load = 1'b0;
    load_pattern = 16'h0000;

    vecs[0] = '{1'b0, 16'h0000, 16'h0222, 16'h0222, 16'd1};
    vecs[1] = '{1'b0, 16'h0000, 16'h0070, 16'h0070, 16'd2};
    vecs[2] = '{1'b1, 16'h0033, 16'h0033, 16'h0033, 16'd1};
    vecs[3] = '{1'b0, 16'h0000, 16'h0033, 16'h0033, 16'd2};
    vecs[4] = '{1'b0, 16'h0000, 16'h0033, 16'h0033, 16'd3};
    vecs[5] = '{1'b1, 16'h00B0, 16'h0000, 16'h0111, 16'd1};

    tick(); tick();
    reset = 1'b0;
    chk("reset_alive", 32'(alive0), 32'h0070);
    chk("reset_gen",   32'(gen0),   32'h0);
    chk("reset_busy",  32'(busy0),  32'h0);
    chk("reset_done",  32'(done0),  32'h0);
    chk("reset_busy_wrap", 32'(busy1), 32'h0);

    // Step-driven generations from a table.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_load) begin
        load_pulse(vecs[i].pat);
        chk($sformatf("v%0d_load_alive", i), 32'(alive0), 32'(vecs[i].pat));
        chk($sformatf("v%0d_load_gen", i),   32'(gen0),   32'h0);
      end
      step_pulse();
      observe(22, bc, dc, da);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd17);
      chk($sformatf("v%0d_done_cnt", i),    32'(dc), 32'd1);
      chk($sformatf("v%0d_done_at", i),     32'(da), 32'd17);
      chk($sformatf("v%0d_alive", i),       32'(alive0), 32'(vecs[i].exp0));
      chk($sformatf("v%0d_alive_wrap", i),  32'(alive1), 32'(vecs[i].exp1));
      chk($sformatf("v%0d_gen", i),         32'(gen0),   32'(vecs[i].exp_gen));
      chk($sformatf("v%0d_gen_wrap", i),    32'(gen1),   32'(vecs[i].exp_gen));
    end

    // Run pacing: every 3rd frame tick starts a generation.
    load_pulse(16'h0070);
    run = 1'b1;
    total_done = 0;
    for (int k = 1; k <= 9; k++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      observe(24, bc, dc, da);
      total_done += dc;
      if (k % 3 == 0) begin
        chk($sformatf("pace_tick%0d_done", k),    32'(dc), 32'd1);
        chk($sformatf("pace_tick%0d_done_at", k), 32'(da), 32'd17);
      end else begin
        chk($sformatf("pace_tick%0d_done", k),    32'(dc), 32'd0);
      end
    end
    chk("pace_total_done", 32'(total_done), 32'd3);
    chk("pace_gen",        32'(gen0),       32'd3);
    chk("pace_alive",      32'(alive0),     32'h0222);

    // run=0: frame ticks are ignored.
    run = 1'b0;
    total_done = 0;
    for (int k = 1; k <= 9; k++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      observe(24, bc, dc, da);
      total_done += dc;
    end
    chk("norun_done", 32'(total_done), 32'd0);
    chk("norun_gen",  32'(gen0),       32'd3);

    // Load abort mid-compute.
    step_pulse();
    tick(); tick(); tick(); tick();
    chk("abort_busy_before", 32'(busy0), 32'h1);
    load_pulse(16'hF000);
    chk("abort_busy",  32'(busy0),  32'h0);
    chk("abort_alive", 32'(alive0), 32'hF000);
    chk("abort_gen",   32'(gen0),   32'h0);
    observe(25, bc, dc, da);
    chk("abort_no_done", 32'(dc), 32'd0);
    chk("abort_alive_hold", 32'(alive0), 32'hF000);

    // Reset mid-compute.
    load_pulse(16'h0033);
    step_pulse();
    observe(22, bc, dc, da);
    chk("pre_reset_gen", 32'(gen0), 32'd1);
    step_pulse();
    for (int n = 0; n < 7; n++) tick();
    chk("mid_busy", 32'(busy0), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_alive", 32'(alive0), 32'h0070);
    chk("midreset_busy",  32'(busy0),  32'h0);
    chk("midreset_gen",   32'(gen0),   32'h0);
    observe(22, bc, dc, da);
    chk("midreset_no_done", 32'(dc), 32'd0);

    // A step during busy is dropped.
    step_pulse();
    tick(); tick(); tick(); tick();
    step_pulse();
    observe(30, bc, dc, da);
    chk("busystep_done_cnt", 32'(dc), 32'd1);
    chk("busystep_gen",      32'(gen0), 32'd1);
    chk("busystep_alive",    32'(alive0), 32'h0222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
